mod_updown_counter_311: RTL and testbench

Parametrised modulo-N up/down counter, the successor to the fixed 8-bit down counter in the counters library. Adds configurable width and modulus, a runtime direction select, count enable, synchronous parallel load, a terminal-count flag and a registered wrap pulse. Intended as the general-purpose counter primitive for dividers, timers and sequencers elsewhere in the design.

---
 rtl/mod_updown_counter_311_if.sv | 23 ++
 rtl/mod_updown_counter_311.sv | 73 +++++++
 tb/tb_mod_updown_counter_311.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_311_if.sv
// Control and status bundle for mod_updown_counter_311.
// The counter (slave) samples en/up/load/load_val on each rising clock and drives count/tc/wrap.
interface mod_updown_counter_311_if #(
    parameter int WIDTH = 8
);
    logic             en_311;
    logic             up_311;
    logic             load_311;
    logic [WIDTH-1:0] load_val_311;
    logic [WIDTH-1:0] count_311;
    logic             tc_311;
    logic             wrap_311;

    modport master (
        output en_311, up_311, load_311, load_val_311,
        input  count_311, tc_311, wrap_311
    );

    modport slave (
        input  en_311, up_311, load_311, load_val_311,
        output count_311, tc_311, wrap_311
    );
endinterface

// File: rtl/mod_updown_counter_311.sv
// Modulo-N up/down counter with parallel load, combinational terminal count and registered wrap pulse.
// Define COUNTER_311_SAT_EN to saturate at the end states instead of wrapping.
module mod_updown_counter_311 #(
    parameter int     WIDTH       = 8,
    parameter longint MODULUS     = 256,
    parameter longint RESET_VALUE = 0
) (
    input logic                     clk_311,
    input logic                     reset_311,
    mod_updown_counter_311_if.slave bus
);
    // All comparisons happen at WIDTH bits, so MODULUS = 2^WIDTH becomes natural overflow.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (count_q == MAX_VAL);
    assign at_bottom = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load_311) begin
            count_d = (bus.load_val_311 > MAX_VAL) ? MAX_VAL : bus.load_val_311;
        end else if (bus.en_311) begin
            if (bus.up_311) begin
                if (at_top) begin
`ifdef COUNTER_311_SAT_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_bottom) begin
`ifdef COUNTER_311_SAT_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_311 or posedge reset_311) begin
        if (reset_311) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // tc flags the cycle whose edge would wrap (or saturate) in the selected direction.
    assign bus.tc_311    = bus.en_311 & ((bus.up_311 & at_top) | (~bus.up_311 & at_bottom));
    assign bus.count_311 = count_q;
    assign bus.wrap_311  = wrap_q;
endmodule

// File: tb/tb_mod_updown_counter_311.sv
// Bench for mod_updown_counter_311: two instances (8-bit mod 10, 4-bit mod 16) checked against an arithmetic model.
module tb_mod_updown_counter_311;
    localparam int WA = 8;
    localparam int MA = 10;
    localparam int WB = 4;
    localparam int MB = 16;

    logic clk_311 = 1'b0;
    logic reset_311;
    always #5 clk_311 = ~clk_311;

    mod_updown_counter_311_if #(.WIDTH(WA)) bus_a ();
    mod_updown_counter_311_if #(.WIDTH(WB)) bus_b ();

    mod_updown_counter_311 #(.WIDTH(WA), .MODULUS(MA), .RESET_VALUE(0)) dut_a (
        .clk_311  (clk_311),
        .reset_311(reset_311),
        .bus      (bus_a)
    );
    mod_updown_counter_311 #(.WIDTH(WB), .MODULUS(MB), .RESET_VALUE(0)) dut_b (
        .clk_311  (clk_311),
        .reset_311(reset_311),
        .bus      (bus_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference state and the inputs currently applied to each instance.
    int cnt_a, cnt_b;
    bit wr_a, wr_b;
    bit en_a, up_a, ld_a, en_b, up_b, ld_b;
    int lv_a, lv_b;
    logic [WA-1:0] exp_q[$];

    function automatic int next_count(input int modulus, input int cnt, input bit en, input bit up,
                                      input bit ld, input int lv, output bit wr);
        int n;
        wr = 1'b0;
        if (ld) return (lv < modulus) ? lv : modulus - 1;
        if (!en) return cnt;
        n = up ? cnt + 1 : cnt - 1;
        if (n >= 0 && n < modulus) return n;
`ifdef COUNTER_311_SAT_EN
        return cnt;
`else
        wr = 1'b1;
        return up ? 0 : modulus - 1;
`endif
    endfunction

    function automatic bit exp_tc(input int modulus, input int cnt, input bit en, input bit up);
        return en && (cnt == (up ? modulus - 1 : 0));
    endfunction

    task automatic set_a(input bit en, input bit up, input bit ld, input int lv);
        en_a = en; up_a = up; ld_a = ld; lv_a = lv;
        bus_a.en_311 = en; bus_a.up_311 = up; bus_a.load_311 = ld;
        bus_a.load_val_311 = WA'(lv);
    endtask

    task automatic set_b(input bit en, input bit up, input bit ld, input int lv);
        en_b = en; up_b = up; ld_b = ld; lv_b = lv;
        bus_b.en_311 = en; bus_b.up_311 = up; bus_b.load_311 = ld;
        bus_b.load_val_311 = WB'(lv);
    endtask

    // Advance one edge on both instances and their models; returns 1 ns after the edge.
    task automatic tick();
        @(posedge clk_311);
        cnt_a = next_count(MA, cnt_a, en_a, up_a, ld_a, lv_a, wr_a);
        cnt_b = next_count(MB, cnt_b, en_b, up_b, ld_b, lv_b, wr_b);
        #1;
    endtask

    task automatic model_reset();
        cnt_a = 0; cnt_b = 0; wr_a = 1'b0; wr_b = 1'b0;
    endtask

    task automatic test_reset();
        reset_311 = 1'b1;
        set_a(1'b1, 1'b0, 1'b0, 0);
        set_b(1'b0, 1'b1, 1'b0, 0);
        model_reset();
        repeat (8) @(posedge clk_311);
        #1;
        tests++; if (bus_a.count_311 !== WA'(0)) begin fails++; $display("FAIL reset_count_a got=%0d exp=0", bus_a.count_311); end
        tests++; if (bus_a.wrap_311 !== 1'b0) begin fails++; $display("FAIL reset_wrap_a got=%b exp=0", bus_a.wrap_311); end
        tests++; if (bus_a.tc_311 !== 1'b1) begin fails++; $display("FAIL reset_tc_down_a got=%b exp=1", bus_a.tc_311); end
        tests++; if (bus_b.count_311 !== WB'(0)) begin fails++; $display("FAIL reset_count_b got=%0d exp=0", bus_b.count_311); end
        tests++; if (bus_b.tc_311 !== 1'b0) begin fails++; $display("FAIL reset_tc_up_b got=%b exp=0", bus_b.tc_311); end
        set_a(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk_311);
        reset_311 = 1'b0;
    endtask

    task automatic test_count_up();
        set_a(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            #1;
            tests++; if (bus_a.tc_311 !== exp_tc(MA, cnt_a, 1'b1, 1'b1)) begin fails++; $display("FAIL up_tc step=%0d got=%b cnt=%0d", i, bus_a.tc_311, cnt_a); end
            tick();
            tests++; if (bus_a.count_311 !== WA'(cnt_a)) begin fails++; $display("FAIL up_count step=%0d got=%0d exp=%0d", i, bus_a.count_311, cnt_a); end
            tests++; if (bus_a.wrap_311 !== wr_a) begin fails++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i, bus_a.wrap_311, wr_a); end
        end
    endtask

    task automatic test_load_down();
        set_a(1'b0, 1'b0, 1'b1, 3);
        tick();
        tests++; if (bus_a.count_311 !== WA'(3)) begin fails++; $display("FAIL load3 got=%0d exp=3", bus_a.count_311); end
        set_a(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (bus_a.tc_311 !== exp_tc(MA, cnt_a, 1'b1, 1'b0)) begin fails++; $display("FAIL down_tc step=%0d got=%b cnt=%0d", i, bus_a.tc_311, cnt_a); end
            tick();
            tests++; if (bus_a.count_311 !== WA'(cnt_a)) begin fails++; $display("FAIL down_count step=%0d got=%0d exp=%0d", i, bus_a.count_311, cnt_a); end
            tests++; if (bus_a.wrap_311 !== wr_a) begin fails++; $display("FAIL down_wrap step=%0d got=%b exp=%b", i, bus_a.wrap_311, wr_a); end
        end
    endtask

    task automatic test_load_clamp();
        set_a(1'b0, 1'b0, 1'b1, 15);
        tick();
        tests++; if (bus_a.count_311 !== WA'(MA - 1)) begin fails++; $display("FAIL load_clamp got=%0d exp=%0d", bus_a.count_311, MA - 1); end
        set_a(1'b1, 1'b1, 1'b1, 5);
        tick();
        tests++; if (bus_a.count_311 !== WA'(5)) begin fails++; $display("FAIL load_wins got=%0d exp=5", bus_a.count_311); end
        tests++; if (bus_a.wrap_311 !== 1'b0) begin fails++; $display("FAIL load_wrap got=%b exp=0", bus_a.wrap_311); end
        set_a(1'b0, 1'b0, 1'b1, 255);
        tick();
        tests++; if (bus_a.count_311 !== WA'(MA - 1)) begin fails++; $display("FAIL load_clamp_max got=%0d exp=%0d", bus_a.count_311, MA - 1); end
    endtask

    task automatic test_direction_toggle();
        set_a(1'b0, 1'b0, 1'b1, 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, (i % 2) == 0, 1'b0, 0);
            tick();
            tests++; if (bus_a.count_311 !== WA'(cnt_a)) begin fails++; $display("FAIL toggle step=%0d got=%0d exp=%0d", i, bus_a.count_311, cnt_a); end
        end
        set_a(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus_a.tc_311 !== 1'b0) begin fails++; $display("FAIL hold_tc step=%0d got=%b exp=0", i, bus_a.tc_311); end
            tick();
            tests++; if (bus_a.count_311 !== WA'(4) || bus_a.wrap_311 !== 1'b0) begin
                fails++; $display("FAIL hold step=%0d count=%0d wrap=%b exp count=4 wrap=0", i, bus_a.count_311, bus_a.wrap_311);
            end
        end
    endtask

    task automatic test_async_reset();
        set_a(1'b0, 1'b0, 1'b1, 6);
        set_b(1'b0, 1'b0, 1'b1, 15);
        tick();
        set_a(1'b1, 1'b1, 1'b0, 0);
        set_b(1'b1, 1'b1, 1'b0, 0);
        tick();
        tests++; if (bus_a.count_311 !== WA'(cnt_a)) begin fails++; $display("FAIL pre_reset_a got=%0d exp=%0d", bus_a.count_311, cnt_a); end
        tests++; if (bus_b.count_311 !== WB'(cnt_b) || bus_b.wrap_311 !== wr_b) begin
            fails++; $display("FAIL wrap_16 count=%0d wrap=%b exp count=%0d wrap=%b", bus_b.count_311, bus_b.wrap_311, cnt_b, wr_b);
        end
        // Reset lands between edges; outputs must clear without waiting for a clock.
        reset_311 = 1'b1;
        model_reset();
        #1;
        tests++; if (bus_a.count_311 !== WA'(0) || bus_a.wrap_311 !== 1'b0) begin
            fails++; $display("FAIL async_reset_a count=%0d wrap=%b exp 0/0", bus_a.count_311, bus_a.wrap_311);
        end
        tests++; if (bus_b.count_311 !== WB'(0) || bus_b.wrap_311 !== 1'b0) begin
            fails++; $display("FAIL async_reset_b count=%0d wrap=%b exp 0/0", bus_b.count_311, bus_b.wrap_311);
        end
        set_a(1'b0, 1'b1, 1'b0, 0);
        set_b(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk_311);
        reset_311 = 1'b0;
    endtask

    task automatic test_random();
        logic [WA-1:0] exp_v;
        for (int i = 0; i < 200; i++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 255));
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 15));
            #1;
            tests++; if (bus_a.tc_311 !== exp_tc(MA, cnt_a, en_a, up_a)) begin fails++; $display("FAIL rand_tc_a i=%0d got=%b cnt=%0d", i, bus_a.tc_311, cnt_a); end
            tests++; if (bus_b.tc_311 !== exp_tc(MB, cnt_b, en_b, up_b)) begin fails++; $display("FAIL rand_tc_b i=%0d got=%b cnt=%0d", i, bus_b.tc_311, cnt_b); end
            tick();
            exp_q.push_back(WA'(cnt_a));
            exp_v = exp_q.pop_front();
            tests++; if (bus_a.count_311 !== exp_v || bus_a.wrap_311 !== wr_a) begin
                fails++; $display("FAIL rand_a i=%0d count=%0d wrap=%b exp count=%0d wrap=%b", i, bus_a.count_311, bus_a.wrap_311, exp_v, wr_a);
            end
            tests++; if (bus_b.count_311 !== WB'(cnt_b) || bus_b.wrap_311 !== wr_b) begin
                fails++; $display("FAIL rand_b i=%0d count=%0d wrap=%b exp count=%0d wrap=%b", i, bus_b.count_311, bus_b.wrap_311, cnt_b, wr_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_load_clamp();
        test_direction_toggle();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
